sipo_packer: RTL
================

SIPO_PACKER -- requirements
Module: sipo_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per assembled word; legal range 2..32.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.
REQ-003 SHALL have port clk_50  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_data  input  1  serial bit, sampled only when data_ena=1.
REQ-006 SHALL have port data_ena  input  1  qualifies serial_data for one bit per cycle.
REQ-007 SHALL have port sync_clr  input  1  synchronous word-framing restart.
REQ-008 SHALL have port fifo_full  input  1  downstream FIFO cannot accept a word this cycle.
REQ-009 SHALL have port ovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-010 SHALL have port to_fifo_data  output  WIDTH  held assembled word.
REQ-011 SHALL have port to_fifo_wr  output  1  FIFO write strobe; a word transfers in every cycle it is 1.
REQ-012 SHALL have port bit_cnt  output  max(1,clog2(WIDTH))  bits collected in the current partial word, 0..WIDTH-1.
REQ-013 SHALL have port overflow  output  1  sticky: a completed word was dropped.

Function
REQ-014 SHALL hold a WIDTH-bit shift register and bit counter; on data_ena=1 the register shifts in serial_data and bit_cnt increments.
REQ-015 SHALL, when LSB_FIRST=1, shift right with serial_data entering bit WIDTH-1; when LSB_FIRST=0, shift left with serial_data entering bit 0.
REQ-016 SHALL complete a word on a data_ena cycle with bit_cnt=WIDTH-1; the completed word includes that cycle's bit; bit_cnt wraps to 0 on that edge.
REQ-017 SHALL implement a two-state output holder, EMPTY and HELD; to_fifo_data updates only on a load into the holder.
REQ-018 SHALL drive to_fifo_wr = (state==HELD) & !fifo_full, combinationally.
REQ-019 EMPTY + word complete -> load word, go to HELD; to_fifo_wr first asserts the next cycle (latency 1 cycle from completing bit).
REQ-020 HELD + to_fifo_wr=1 + no completion -> go to EMPTY; to_fifo_data keeps its last value.
REQ-021 HELD + to_fifo_wr=1 + completion on the same edge -> load new word, remain HELD; no data loss.
REQ-022 HELD + fifo_full=1 + completion -> drop new word, keep held word, set overflow; bit_cnt still wraps to 0.
REQ-023 SHALL keep overflow at 1 until ovf_clr=1; if ovf_clr and a new drop occur on the same edge, overflow SHALL be 1 (set wins).
REQ-024 sync_clr=1 with data_ena=0 -> bit_cnt=0 and partial word discarded; holder and overflow unaffected.
REQ-025 sync_clr=1 with data_ena=1 -> partial word discarded, that cycle's bit is the first bit of a new word, bit_cnt=1; no completion occurs that cycle.
REQ-026 SHALL never assert to_fifo_wr on two cycles for a single loaded word.

Reset
REQ-027 On reset=1, independent of clk_50: shift register=0, bit_cnt=0, state=EMPTY, to_fifo_data=0, to_fifo_wr=0, overflow=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; the first data_ena bit after release SHALL be bit index 0 of a new word.
REQ-029 SHALL sample no data_ena bit in a cycle where reset is 1.

Verification (WIDTH=8 unless noted)
REQ-030 LSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive data_ena cycles, fifo_full=0 -> one-cycle to_fifo_wr with to_fifo_data=0x4D, cycle after 8th bit.
REQ-031 LSB_FIRST=0, same bit sequence -> to_fifo_data=0xB2, one to_fifo_wr pulse.
REQ-032 fifo_full=1 held through two full words 0x4D then 0xFF -> to_fifo_data stays 0x4D, overflow=1; release fifo_full -> one to_fifo_wr with 0x4D; ovf_clr pulse -> overflow=0.
REQ-033 fifo_full=1 over word 0x4D, release on the edge that completes the next word 0x11 -> to_fifo_wr writes 0x4D, then the following cycle writes 0x11, overflow=0.
REQ-034 3 bits sent, sync_clr with data_ena=1 and bit 1, then 7 bits 0 -> bit_cnt=1 after clear, completed word=0x01 (LSB_FIRST=1).
REQ-035 reset asserted after 5 bits, released, then 8 bits all 1 -> all outputs 0 during reset, then to_fifo_data=0xFF, exactly one to_fifo_wr pulse.

Source files
------------

// File: rtl/sipo_packer.sv
//------------------------------------------------------------------------------
// Module   : sipo_packer
// Function : Serial-in parallel-out word packer with a one-word output holder
//            feeding a downstream FIFO. Dropped words set a sticky overflow.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_packer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       serial_data,
    input  logic                       data_ena,
    input  logic                       sync_clr,
    input  logic                       fifo_full,
    input  logic                       ovf_clr,
    output logic [WIDTH-1:0]           to_fifo_data,
    output logic                       to_fifo_wr,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overflow
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     r_data;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic                 r_overflow;

    logic [WIDTH-1:0]     w_shift_base;
    logic [WIDTH-1:0]     w_shift_next;
    logic [WIDTH-1:0]     w_shift_d;
    logic [c_CNT_W-1:0]   w_bit_cnt_next;
    logic                 w_complete;
    logic                 w_wr;
    logic                 w_load;
    logic                 w_drop;

    // A framing restart discards the partial word before this cycle's bit enters.
    assign w_shift_base = sync_clr ? '0 : r_shift;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift_next = {serial_data, w_shift_base[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_next = {w_shift_base[WIDTH-2:0], serial_data};
        end
    endgenerate

    assign w_complete = data_ena && !sync_clr && (r_bit_cnt == c_LAST);
    assign w_wr       = (r_state == HELD) && !fifo_full;

    always_comb begin
        w_shift_d      = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        if (data_ena) begin
            w_shift_d = w_shift_next;
            if (sync_clr) begin
                w_bit_cnt_next = c_CNT_W'(1);
            end else if (w_complete) begin
                w_bit_cnt_next = '0;
            end else begin
                w_bit_cnt_next = r_bit_cnt + c_CNT_W'(1);
            end
        end else if (sync_clr) begin
            w_shift_d      = '0;
            w_bit_cnt_next = '0;
        end
    end

    // Holder: a completed word is taken only if the slot is free or being drained.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = HELD;
                end
            end
            HELD: begin
                if (w_wr) begin
                    if (w_complete) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end else if (w_complete) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_d;
            r_bit_cnt  <= w_bit_cnt_next;
            r_overflow <= w_drop || (r_overflow && !ovf_clr);
            if (w_load) begin
                r_data <= w_shift_next;
            end
        end
    end

    assign to_fifo_data = r_data;
    assign to_fifo_wr   = w_wr;
    assign bit_cnt      = r_bit_cnt;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
